// File: rtl/clock_pkg.sv
// Shared mode/turn encodings for the front-panel controller and the time-set / alarm-set datapaths.
package clock_pkg;

   localparam logic [1:0] MODE_RUN       = 2'd0;
   localparam logic [1:0] MODE_TIME_SET  = 2'd1;
   localparam logic [1:0] MODE_ALARM_SET = 2'd2;

   localparam logic TURN_HOUR = 1'b1;
   localparam logic TURN_MIN  = 1'b0;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_TIME_SET  = 2'd1,
      ST_ALARM_SET = 2'd2
   } mode_e;

   function automatic logic is_set_mode(input logic [1:0] m);
      return (m == MODE_TIME_SET) || (m == MODE_ALARM_SET);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, and a one-clk press
// pulse that coincides with the accepted 0->1 transition of level.
module btn_debounce #(
   parameter int DB_CYCLES = 50000,
   parameter int DB_W      = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press
);

   logic            sync1;
   logic            sync2;
   logic [DB_W-1:0] cnt;
   logic            accept;

   assign accept = (sync2 != level) && (cnt == DB_W'(DB_CYCLES - 1));
   assign press  = accept && sync2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (accept) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + DB_W'(1);
         end
      end
   end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Front-panel controller: debounced buttons drive the RUN/TIME_SET/ALARM_SET FSM,
// idle auto-return, and alarm ring timing.
//
//  state        | meaning
//  ST_RUN       | normal display, sel/inc ignored
//  ST_TIME_SET  | editing time, sel toggles field, inc strobes change
//  ST_ALARM_SET | editing alarm, same controls as ST_TIME_SET
module clock_mode_ctrl
   import clock_pkg::*;
#(
   parameter int DB_CYCLES = 50000,
   parameter int DB_W      = 16,
   parameter int IDLE_SECS = 30,
   parameter int RING_SECS = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_mode_raw,
   input  logic       btn_sel_raw,
   input  logic       btn_inc_raw,
   input  logic       sec_tick,
   input  logic [7:0] hour,
   input  logic [7:0] minute,
   input  logic [7:0] alarm_hour,
   input  logic [7:0] alarm_minute,
   input  logic       alarm_en,
   output logic [1:0] mode,
   output logic       turn,
   output logic       change,
   output logic       ring
);

   localparam int IDLE_W = $clog2(IDLE_SECS + 1);
   localparam int RING_W = $clog2(RING_SECS + 1);

   logic              lvl_mode, lvl_sel, lvl_inc;
   logic              press_mode, press_sel, press_inc, any_press;
   logic              match, match_q, ring_expire, set_mode;
   logic [IDLE_W-1:0] idle_cnt;
   logic [RING_W-1:0] ring_cnt;
   mode_e             mode_q;

   btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_mode (
      .clk(clk), .rst_n(rst_n), .raw(btn_mode_raw), .level(lvl_mode), .press(press_mode));
   btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_sel (
      .clk(clk), .rst_n(rst_n), .raw(btn_sel_raw), .level(lvl_sel), .press(press_sel));
   btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_inc (
      .clk(clk), .rst_n(rst_n), .raw(btn_inc_raw), .level(lvl_inc), .press(press_inc));

   assign any_press   = press_mode || press_sel || press_inc;
   assign match       = alarm_en && (hour == alarm_hour) && (minute == alarm_minute);
   assign ring_expire = sec_tick && (ring_cnt == RING_W'(1));
   assign set_mode    = is_set_mode(mode_q);
   assign mode        = mode_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q   <= ST_RUN;
         turn     <= TURN_HOUR;
         change   <= 1'b0;
         ring     <= 1'b0;
         match_q  <= 1'b0;
         idle_cnt <= '0;
         ring_cnt <= '0;
      end else begin
         match_q <= match;
         change  <= 1'b0;

         // Ring timer counts down from RING_SECS; a press or disarm cancels it, and a
         // cancelling condition in the rising cycle suppresses the rise.
         if (ring) begin
            if (any_press || !alarm_en || ring_expire) begin
               ring     <= 1'b0;
               ring_cnt <= '0;
            end else if (sec_tick) begin
               ring_cnt <= ring_cnt - RING_W'(1);
            end
         end else if (match && !match_q && !any_press) begin
            ring     <= 1'b1;
            ring_cnt <= RING_W'(RING_SECS);
         end

         case (mode_q)
            ST_RUN, ST_TIME_SET, ST_ALARM_SET: begin
               if (any_press) begin
                  idle_cnt <= '0;
                  if (!ring) begin
                     if (press_mode) begin
                        case (mode_q)
                           ST_RUN:       mode_q <= ST_TIME_SET;
                           ST_TIME_SET:  mode_q <= ST_ALARM_SET;
                           default:      mode_q <= ST_RUN;
                        endcase
                        if (mode_q != ST_ALARM_SET) turn <= TURN_HOUR;
                     end else if (press_sel) begin
                        if (set_mode) turn <= ~turn;
                     end else if (set_mode) begin
                        change <= 1'b1;
                     end
                  end
               end else if (set_mode && sec_tick) begin
                  if (idle_cnt == IDLE_W'(IDLE_SECS - 1)) begin
                     mode_q   <= ST_RUN;
                     turn     <= TURN_HOUR;
                     idle_cnt <= '0;
                  end else begin
                     idle_cnt <= idle_cnt + IDLE_W'(1);
                  end
               end
            end
            default: mode_q <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with short debounce and timer settings.
module tb_clock_mode_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_mode_raw, btn_sel_raw, btn_inc_raw;
   logic       sec_tick;
   logic [7:0] hour, minute, alarm_hour, alarm_minute;
   logic       alarm_en;
   logic [1:0] mode;
   logic       turn, change, ring;

   int checks   = 0;
   int failures = 0;
   int chg_cnt  = 0;
   int chg_dbl  = 0;
   logic chg_prev = 1'b0;
   int base;

   clock_mode_ctrl #(.DB_CYCLES(4), .DB_W(3), .IDLE_SECS(3), .RING_SECS(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_mode_raw(btn_mode_raw), .btn_sel_raw(btn_sel_raw), .btn_inc_raw(btn_inc_raw),
      .sec_tick(sec_tick), .hour(hour), .minute(minute),
      .alarm_hour(alarm_hour), .alarm_minute(alarm_minute), .alarm_en(alarm_en),
      .mode(mode), .turn(turn), .change(change), .ring(ring));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (change) chg_cnt++;
      if (change && chg_prev) chg_dbl++;
      chg_prev = change;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // 0=mode 1=sel 2=inc
   task automatic press(input int which);
      @(negedge clk);
      if (which == 0) btn_mode_raw = 1'b1;
      if (which == 1) btn_sel_raw  = 1'b1;
      if (which == 2) btn_inc_raw  = 1'b1;
      cyc(8);
      btn_mode_raw = 1'b0;
      btn_sel_raw  = 1'b0;
      btn_inc_raw  = 1'b0;
      cyc(8);
   endtask

   task automatic tick();
      @(negedge clk);
      sec_tick = 1'b1;
      @(negedge clk);
      sec_tick = 1'b0;
   endtask

   task automatic rearm();
      @(negedge clk);
      minute = 8'h31;
      cyc(2);
      minute = 8'h30;
      cyc(1);
   endtask

   initial begin
      rst_n = 1'b0;
      btn_mode_raw = 1'b0; btn_sel_raw = 1'b0; btn_inc_raw = 1'b0;
      sec_tick = 1'b0;
      hour = 8'h12; minute = 8'h00;
      alarm_hour = 8'h07; alarm_minute = 8'h30; alarm_en = 1'b1;
      cyc(3);
      chk("reset_mode", mode, 0);
      chk("reset_turn", turn, 1);
      chk("reset_change", change, 0);
      chk("reset_ring", ring, 0);
      rst_n = 1'b1;
      cyc(2);

      // 3-cycle glitch is rejected
      btn_mode_raw = 1'b1;
      cyc(3);
      btn_mode_raw = 1'b0;
      cyc(10);
      chk("glitch_mode", mode, 0);

      // held press: accepted on the 6th edge after the raw edge
      btn_mode_raw = 1'b1;
      cyc(5);
      chk("latency_5", mode, 0);
      cyc(1);
      chk("latency_6", mode, 1);
      cyc(4);
      btn_mode_raw = 1'b0;
      cyc(8);
      chk("held_once", mode, 1);
      chk("held_turn", turn, 1);

      press(0); chk("cycle_2", mode, 2); chk("cycle_2_turn", turn, 1);
      press(0); chk("cycle_0", mode, 0);
      press(0); chk("cycle_1", mode, 1); chk("cycle_1_turn", turn, 1);

      // alarm-set editing
      press(0); chk("set_mode2", mode, 2);
      press(1); chk("sel_turn0", turn, 0);
      base = chg_cnt;
      press(2); press(2); press(2);
      chk("inc_pulses", chg_cnt - base, 3);
      chk("inc_no_double", chg_dbl, 0);
      chk("inc_turn_kept", turn, 0);

      // RUN ignores inc and sel
      press(0); chk("back_run", mode, 0);
      base = chg_cnt;
      press(2); press(2); press(2);
      chk("run_inc_none", chg_cnt - base, 0);
      press(1); chk("run_sel_ignored", turn, 0);

      // mode and inc accepted together: mode wins
      base = chg_cnt;
      @(negedge clk);
      btn_mode_raw = 1'b1; btn_inc_raw = 1'b1;
      cyc(8);
      btn_mode_raw = 1'b0; btn_inc_raw = 1'b0;
      cyc(8);
      chk("simul_mode", mode, 1);
      chk("simul_nochange", chg_cnt - base, 0);
      chk("simul_turn", turn, 1);

      // idle timeout, restarted by a press
      tick(); tick();
      chk("idle_2ticks", mode, 1);
      press(1);
      chk("idle_sel_turn", turn, 0);
      tick(); tick();
      chk("idle_restart", mode, 1);
      tick();
      chk("idle_timeout_mode", mode, 0);
      chk("idle_timeout_turn", turn, 1);

      // alarm ring and timeout
      hour = 8'h07; minute = 8'h29;
      cyc(2);
      chk("pre_alarm", ring, 0);
      minute = 8'h30;
      cyc(1);
      chk("ring_rise", ring, 1);
      tick();
      chk("ring_after_1tick", ring, 1);
      tick();
      chk("ring_after_2tick", ring, 0);
      cyc(4);
      chk("ring_no_rearm", ring, 0);

      // sel press cancels ring without touching turn
      press(0);
      chk("alarm_set_mode1", mode, 1);
      rearm();
      chk("ring_rise2", ring, 1);
      press(1);
      chk("ring_sel_clear", ring, 0);
      chk("ring_sel_turn", turn, 1);
      chk("ring_sel_mode", mode, 1);

      // disarming clears ring
      rearm();
      chk("ring_rise3", ring, 1);
      alarm_en = 1'b0;
      cyc(1);
      chk("ring_disarm", ring, 0);

      // re-arming while time matches rings again; reset mid-ring
      alarm_en = 1'b1;
      cyc(1);
      chk("ring_rearm_en", ring, 1);
      rst_n = 1'b0;
      cyc(1);
      chk("rst_ring", ring, 0);
      chk("rst_mode", mode, 0);
      chk("rst_turn", turn, 1);
      minute = 8'h00;
      cyc(1);
      rst_n = 1'b1;
      cyc(2);
      chk("post_rst_ring", ring, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
